// File: rtl/mau_pkg.sv
// Shared constants for the memory access unit: op fields, size codes, exception codes, FSM states.
package mau_pkg;

    localparam int unsigned OP_WE  = 3;
    localparam int unsigned OP_UNS = 2;
    localparam int unsigned CNT_W  = 8;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    localparam logic [1:0] EXC_NONE    = 2'd0;
    localparam logic [1:0] EXC_LD_ADDR = 2'd1;
    localparam logic [1:0] EXC_ST_ADDR = 2'd2;
    localparam logic [1:0] EXC_BUS     = 2'd3;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_REQ  = 2'd1;
    localparam state_t ST_RESP = 2'd2;

    // True when the low address bits are not a multiple of the access size.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] addr_lo);
        case (size)
            SZ_H:    return addr_lo[0];
            SZ_W:    return |addr_lo[1:0];
            SZ_D:    return |addr_lo;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mau_lane_align.sv
// Byte-lane steering: byte enables and store shift toward the bus, load extract and extend from it.
module mau_lane_align
    import mau_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [1:0]                    size,
    input  logic                          uns,
    input  logic [$clog2(DATA_W/8)-1:0]   off,
    input  logic [DATA_W-1:0]             wdata,
    input  logic [DATA_W-1:0]             rdata,
    output logic [DATA_W/8-1:0]           be_c,
    output logic [DATA_W-1:0]             wdata_c,
    output logic [DATA_W-1:0]             rdata_c
);

    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned OFF_W = $clog2(NB);

    logic [NB-1:0]      be_base;
    logic [DATA_W-1:0]  mask;
    logic [DATA_W-1:0]  field;
    logic [OFF_W+2:0]   sh;

    // Size-derived masks, lane shifts and sign/zero extension of the loaded field.
    always_comb begin
        be_base = NB'(8'hFF);
        mask    = '1;
        case (size)
            SZ_B: begin be_base = NB'(8'h01); mask = DATA_W'(64'h0000_0000_0000_00FF); end
            SZ_H: begin be_base = NB'(8'h03); mask = DATA_W'(64'h0000_0000_0000_FFFF); end
            SZ_W: begin be_base = NB'(8'h0F); mask = DATA_W'(64'h0000_0000_FFFF_FFFF); end
            default: ;
        endcase
        sh      = {off, 3'b000};
        be_c    = be_base << off;
        wdata_c = (wdata & mask) << sh;
        field   = rdata >> sh;
        rdata_c = field;
        case (size)
            SZ_B: rdata_c = uns ? DATA_W'(field[7:0])  : DATA_W'($signed(field[7:0]));
            SZ_H: rdata_c = uns ? DATA_W'(field[15:0]) : DATA_W'($signed(field[15:0]));
            SZ_W: rdata_c = uns ? DATA_W'(field[31:0]) : DATA_W'($signed(field[31:0]));
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: accepts one request, runs a single bus transaction, returns an extended result.
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            in_op,
    input  logic [ADDR_W-1:0]     in_addr,
    input  logic [DATA_W-1:0]     in_wdata,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [ADDR_W-1:0]     bus_addr,
    output logic [DATA_W/8-1:0]   bus_be,
    output logic [DATA_W-1:0]     bus_wdata,
    input  logic                  bus_ack,
    input  logic                  bus_err,
    input  logic [DATA_W-1:0]     bus_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_rdata,
    output logic [1:0]            out_exc
);

    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned OFF_W = $clog2(NB);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [3:0]          op_q, op_d;
    logic [OFF_W-1:0]    off_q, off_d;
    logic                in_ready_q, in_ready_d;
    logic                bus_req_q, bus_req_d;
    logic                bus_we_q, bus_we_d;
    logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
    logic [NB-1:0]       bus_be_q, bus_be_d;
    logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_rdata_q, out_rdata_d;
    logic [1:0]          out_exc_q, out_exc_d;

    logic [1:0]          la_size;
    logic                la_uns;
    logic [OFF_W-1:0]    la_off;
    logic [NB-1:0]       la_be_c;
    logic [DATA_W-1:0]   la_wdata_c, la_rdata_c;
    logic                bad_addr_c;

    // Steer the aligner from the live request while idle, from the latched request otherwise.
    always_comb begin
        la_size    = (state_q == ST_IDLE) ? in_op[1:0]          : op_q[1:0];
        la_uns     = (state_q == ST_IDLE) ? in_op[OP_UNS]       : op_q[OP_UNS];
        la_off     = (state_q == ST_IDLE) ? in_addr[OFF_W-1:0]  : off_q;
        bad_addr_c = is_misaligned(in_op[1:0], in_addr[2:0]) || ((in_op[1:0] == SZ_D) && (DATA_W != 64));
    end

    mau_lane_align #(.DATA_W(DATA_W)) u_lane_align (
        .size    (la_size),
        .uns     (la_uns),
        .off     (la_off),
        .wdata   (in_wdata),
        .rdata   (bus_rdata),
        .be_c    (la_be_c),
        .wdata_c (la_wdata_c),
        .rdata_c (la_rdata_c)
    );

    // Next-state and registered-output logic for IDLE -> (REQ) -> RESP -> IDLE.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        off_d       = off_q;
        in_ready_d  = in_ready_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        out_valid_d = out_valid_q;
        out_rdata_d = out_rdata_q;
        out_exc_d   = out_exc_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    op_d       = in_op;
                    off_d      = in_addr[OFF_W-1:0];
                    in_ready_d = 1'b0;
                    if (bad_addr_c) begin
                        state_d     = ST_RESP;
                        out_valid_d = 1'b1;
                        out_rdata_d = '0;
                        out_exc_d   = in_op[OP_WE] ? EXC_ST_ADDR : EXC_LD_ADDR;
                    end else begin
                        state_d     = ST_REQ;
                        cnt_d       = '0;
                        bus_req_d   = 1'b1;
                        bus_we_d    = in_op[OP_WE];
                        bus_addr_d  = in_addr;
                        bus_addr_d[OFF_W-1:0] = '0;
                        bus_be_d    = la_be_c;
                        bus_wdata_d = la_wdata_c;
                    end
                end
            end
            ST_REQ: begin
                if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
                if (bus_err || (!bus_ack && (cnt_q >= CNT_LAST))) begin
                    state_d     = ST_RESP;
                    bus_req_d   = 1'b0;
                    out_valid_d = 1'b1;
                    out_rdata_d = '0;
                    out_exc_d   = EXC_BUS;
                end else if (bus_ack) begin
                    state_d     = ST_RESP;
                    bus_req_d   = 1'b0;
                    out_valid_d = 1'b1;
                    out_rdata_d = op_q[OP_WE] ? '0 : la_rdata_c;
                    out_exc_d   = EXC_NONE;
                end
            end
            ST_RESP: begin
                if (out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                bus_req_d   = 1'b0;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            off_q       <= '0;
            in_ready_q  <= 1'b1;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_be_q    <= '0;
            bus_wdata_q <= '0;
            out_valid_q <= 1'b0;
            out_rdata_q <= '0;
            out_exc_q   <= EXC_NONE;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            off_q       <= off_d;
            in_ready_q  <= in_ready_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            out_valid_q <= out_valid_d;
            out_rdata_q <= out_rdata_d;
            out_exc_q   <= out_exc_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_be    = bus_be_q;
    assign bus_wdata = bus_wdata_q;
    assign out_valid = out_valid_q;
    assign out_rdata = out_rdata_q;
    assign out_exc   = out_exc_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a 32-bit instance (TIMEOUT=8) and a 64-bit instance.
module tb_mem_access_unit;

    logic clk = 1'b0;
    logic rst_n;

    logic        a_in_valid, a_in_ready;
    logic [3:0]  a_in_op;
    logic [31:0] a_in_addr, a_in_wdata;
    logic        a_bus_req, a_bus_we;
    logic [31:0] a_bus_addr, a_bus_wdata, a_bus_rdata;
    logic [3:0]  a_bus_be;
    logic        a_bus_ack, a_bus_err;
    logic        a_out_valid, a_out_ready;
    logic [31:0] a_out_rdata;
    logic [1:0]  a_out_exc;

    logic        b_in_valid, b_in_ready;
    logic [3:0]  b_in_op;
    logic [31:0] b_in_addr;
    logic [63:0] b_in_wdata;
    logic        b_bus_req, b_bus_we;
    logic [31:0] b_bus_addr;
    logic [63:0] b_bus_wdata, b_bus_rdata;
    logic [7:0]  b_bus_be;
    logic        b_bus_ack, b_bus_err;
    logic        b_out_valid, b_out_ready;
    logic [63:0] b_out_rdata;
    logic [1:0]  b_out_exc;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(8)) dut32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_op(a_in_op),
        .in_addr(a_in_addr), .in_wdata(a_in_wdata),
        .bus_req(a_bus_req), .bus_we(a_bus_we), .bus_addr(a_bus_addr),
        .bus_be(a_bus_be), .bus_wdata(a_bus_wdata),
        .bus_ack(a_bus_ack), .bus_err(a_bus_err), .bus_rdata(a_bus_rdata),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_rdata(a_out_rdata), .out_exc(a_out_exc)
    );

    mem_access_unit #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(16)) dut64 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_op(b_in_op),
        .in_addr(b_in_addr), .in_wdata(b_in_wdata),
        .bus_req(b_bus_req), .bus_we(b_bus_we), .bus_addr(b_bus_addr),
        .bus_be(b_bus_be), .bus_wdata(b_bus_wdata),
        .bus_ack(b_bus_ack), .bus_err(b_bus_err), .bus_rdata(b_bus_rdata),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_rdata(b_out_rdata), .out_exc(b_out_exc)
    );

    // Present one request for one cycle; returns on the negedge after the accept edge.
    task automatic send32(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd);
        a_in_valid = 1'b1; a_in_op = op; a_in_addr = addr; a_in_wdata = wd;
        @(negedge clk);
        a_in_valid = 1'b0;
    endtask

    task automatic ack32(input logic [31:0] rd);
        a_bus_ack = 1'b1; a_bus_rdata = rd;
        @(negedge clk);
        a_bus_ack = 1'b0;
    endtask

    task automatic drain32();
        a_out_ready = 1'b1;
        @(negedge clk);
        a_out_ready = 1'b0;
    endtask

    task automatic send64(input logic [3:0] op, input logic [31:0] addr, input logic [63:0] wd);
        b_in_valid = 1'b1; b_in_op = op; b_in_addr = addr; b_in_wdata = wd;
        @(negedge clk);
        b_in_valid = 1'b0;
    endtask

    task automatic ack64(input logic [63:0] rd);
        b_bus_ack = 1'b1; b_bus_rdata = rd;
        @(negedge clk);
        b_bus_ack = 1'b0;
    endtask

    task automatic drain64();
        b_out_ready = 1'b1;
        @(negedge clk);
        b_out_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        vecs++;
        if (a_bus_req !== 1'b0 || a_bus_we !== 1'b0 || a_bus_be !== 4'h0 || a_bus_addr !== 32'h0 || a_bus_wdata !== 32'h0) begin
            errs++;
            $display("FAIL reset_bus: req=%b we=%b be=%h addr=%h wdata=%h, want all zero", a_bus_req, a_bus_we, a_bus_be, a_bus_addr, a_bus_wdata);
        end
        vecs++;
        if (a_out_valid !== 1'b0 || a_out_rdata !== 32'h0 || a_out_exc !== 2'd0 || b_out_valid !== 1'b0 || b_bus_req !== 1'b0) begin
            errs++;
            $display("FAIL reset_out: valid=%b rdata=%h exc=%0d b_valid=%b b_req=%b, want all zero", a_out_valid, a_out_rdata, a_out_exc, b_out_valid, b_bus_req);
        end
        rst_n = 1'b1;
        @(negedge clk);
        vecs++;
        if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
            errs++;
            $display("FAIL reset_ready: in_ready=%b/%b, want 1/1", a_in_ready, b_in_ready);
        end
    endtask

    task automatic test_load_byte();
        send32(4'h0, 32'h0000_1001, 32'h0);
        vecs++;
        if (a_bus_req !== 1'b1 || a_bus_we !== 1'b0 || a_bus_addr !== 32'h0000_1000 || a_bus_be !== 4'b0010 || a_in_ready !== 1'b0) begin
            errs++;
            $display("FAIL lb_req: req=%b we=%b addr=%h be=%b rdy=%b, want 1 0 00001000 0010 0", a_bus_req, a_bus_we, a_bus_addr, a_bus_be, a_in_ready);
        end
        ack32(32'h1234_80FF);
        vecs++;
        if (a_out_valid !== 1'b1 || a_out_exc !== 2'd0 || a_out_rdata !== 32'hFFFF_FF80 || a_bus_req !== 1'b0) begin
            errs++;
            $display("FAIL lb_resp: valid=%b exc=%0d rdata=%h req=%b, want 1 0 ffffff80 0", a_out_valid, a_out_exc, a_out_rdata, a_bus_req);
        end
        drain32();
        vecs++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
            errs++;
            $display("FAIL lb_idle: valid=%b rdy=%b, want 0 1", a_out_valid, a_in_ready);
        end
        send32(4'h4, 32'h0000_1001, 32'h0);
        ack32(32'h1234_80FF);
        vecs++;
        if (a_out_valid !== 1'b1 || a_out_rdata !== 32'h0000_0080) begin
            errs++;
            $display("FAIL lbu_resp: valid=%b rdata=%h, want 1 00000080", a_out_valid, a_out_rdata);
        end
        drain32();
        send32(4'h1, 32'h0000_0002, 32'h0);
        ack32(32'hABCD_1234);
        vecs++;
        if (a_out_rdata !== 32'hFFFF_ABCD || a_out_exc !== 2'd0) begin
            errs++;
            $display("FAIL lh_resp: rdata=%h exc=%0d, want ffffabcd 0", a_out_rdata, a_out_exc);
        end
        drain32();
    endtask

    task automatic test_store();
        send32(4'h9, 32'h0000_0006, 32'h0000_BEEF);
        vecs++;
        if (a_bus_req !== 1'b1 || a_bus_we !== 1'b1 || a_bus_addr !== 32'h4 || a_bus_be !== 4'b1100 || a_bus_wdata !== 32'hBEEF_0000) begin
            errs++;
            $display("FAIL sh_req: req=%b we=%b addr=%h be=%b wdata=%h, want 1 1 00000004 1100 beef0000", a_bus_req, a_bus_we, a_bus_addr, a_bus_be, a_bus_wdata);
        end
        ack32(32'hFFFF_FFFF);
        vecs++;
        if (a_out_valid !== 1'b1 || a_out_exc !== 2'd0 || a_out_rdata !== 32'h0) begin
            errs++;
            $display("FAIL sh_resp: valid=%b exc=%0d rdata=%h, want 1 0 00000000", a_out_valid, a_out_exc, a_out_rdata);
        end
        drain32();
        send32(4'h8, 32'h0000_0003, 32'hA5A5_A555);
        vecs++;
        if (a_bus_be !== 4'b1000 || a_bus_wdata !== 32'h5500_0000 || a_bus_addr !== 32'h0) begin
            errs++;
            $display("FAIL sb_req: be=%b wdata=%h addr=%h, want 1000 55000000 00000000", a_bus_be, a_bus_wdata, a_bus_addr);
        end
        ack32(32'h0);
        drain32();
        send32(4'hA, 32'h0000_0008, 32'hDEAD_BEEF);
        vecs++;
        if (a_bus_be !== 4'b1111 || a_bus_wdata !== 32'hDEAD_BEEF || a_bus_addr !== 32'h8) begin
            errs++;
            $display("FAIL sw_req: be=%b wdata=%h addr=%h, want 1111 deadbeef 00000008", a_bus_be, a_bus_wdata, a_bus_addr);
        end
        ack32(32'h0);
        drain32();
    endtask

    task automatic test_addr_exc();
        send32(4'h2, 32'h0000_0002, 32'h0);
        vecs++;
        if (a_out_valid !== 1'b1 || a_out_exc !== 2'd1 || a_bus_req !== 1'b0 || a_out_rdata !== 32'h0) begin
            errs++;
            $display("FAIL lw_misalign: valid=%b exc=%0d req=%b rdata=%h, want 1 1 0 00000000", a_out_valid, a_out_exc, a_bus_req, a_out_rdata);
        end
        drain32();
        send32(4'hA, 32'h0000_0003, 32'h1234_5678);
        vecs++;
        if (a_out_valid !== 1'b1 || a_out_exc !== 2'd2 || a_bus_req !== 1'b0) begin
            errs++;
            $display("FAIL sw_misalign: valid=%b exc=%0d req=%b, want 1 2 0", a_out_valid, a_out_exc, a_bus_req);
        end
        drain32();
        send32(4'h3, 32'h0000_0000, 32'h0);
        vecs++;
        if (a_out_valid !== 1'b1 || a_out_exc !== 2'd1 || a_bus_req !== 1'b0) begin
            errs++;
            $display("FAIL ld_on_32: valid=%b exc=%0d req=%b, want 1 1 0", a_out_valid, a_out_exc, a_bus_req);
        end
        drain32();
        send32(4'hB, 32'h0000_0010, 32'h0);
        vecs++;
        if (a_out_exc !== 2'd2 || a_bus_req !== 1'b0) begin
            errs++;
            $display("FAIL sd_on_32: exc=%0d req=%b, want 2 0", a_out_exc, a_bus_req);
        end
        drain32();
        send32(4'h1, 32'h0000_0011, 32'h0);
        vecs++;
        if (a_out_exc !== 2'd1 || a_bus_req !== 1'b0) begin
            errs++;
            $display("FAIL lh_misalign: exc=%0d req=%b, want 1 0", a_out_exc, a_bus_req);
        end
        drain32();
    endtask

    task automatic test_timeout();
        int n;
        n = 0;
        send32(4'h2, 32'h0000_0100, 32'h0);
        for (int i = 0; i < 20; i++) begin
            if (a_bus_req === 1'b1) n++;
            @(negedge clk);
        end
        vecs++;
        if (n != 8) begin
            errs++;
            $display("FAIL timeout_len: bus_req high %0d cycles, want 8", n);
        end
        vecs++;
        if (a_out_valid !== 1'b1 || a_out_exc !== 2'd3 || a_out_rdata !== 32'h0) begin
            errs++;
            $display("FAIL timeout_resp: valid=%b exc=%0d rdata=%h, want 1 3 00000000", a_out_valid, a_out_exc, a_out_rdata);
        end
        drain32();
        send32(4'h2, 32'h0000_0104, 32'h0);
        repeat (7) @(negedge clk);
        vecs++;
        if (a_bus_req !== 1'b1 || a_out_valid !== 1'b0) begin
            errs++;
            $display("FAIL late_ack_req: req=%b valid=%b, want 1 0", a_bus_req, a_out_valid);
        end
        ack32(32'hCAFE_F00D);
        vecs++;
        if (a_out_valid !== 1'b1 || a_out_exc !== 2'd0 || a_out_rdata !== 32'hCAFE_F00D) begin
            errs++;
            $display("FAIL late_ack_resp: valid=%b exc=%0d rdata=%h, want 1 0 cafef00d", a_out_valid, a_out_exc, a_out_rdata);
        end
        drain32();
    endtask

    task automatic test_ack_err();
        send32(4'h2, 32'h0000_0040, 32'h0);
        a_bus_ack = 1'b1; a_bus_err = 1'b1; a_bus_rdata = 32'h1111_1111;
        @(negedge clk);
        a_bus_ack = 1'b0; a_bus_err = 1'b0;
        vecs++;
        if (a_out_valid !== 1'b1 || a_out_exc !== 2'd3 || a_out_rdata !== 32'h0 || a_bus_req !== 1'b0) begin
            errs++;
            $display("FAIL ack_err: valid=%b exc=%0d rdata=%h req=%b, want 1 3 00000000 0", a_out_valid, a_out_exc, a_out_rdata, a_bus_req);
        end
        drain32();
    endtask

    task automatic test_resp_stall();
        int bad;
        bad = 0;
        send32(4'h5, 32'h0000_0002, 32'h0);
        ack32(32'hABCD_1234);
        for (int i = 0; i < 5; i++) begin
            if (a_out_valid !== 1'b1 || a_out_rdata !== 32'h0000_ABCD || a_out_exc !== 2'd0 || a_in_ready !== 1'b0 || a_bus_req !== 1'b0) bad++;
            a_bus_ack = (i == 1); a_bus_err = (i == 2); a_in_valid = (i == 3);
            @(negedge clk);
        end
        a_bus_ack = 1'b0; a_bus_err = 1'b0; a_in_valid = 1'b0;
        vecs++;
        if (bad != 0) begin
            errs++;
            $display("FAIL resp_stall: %0d of 5 cycles unstable (valid=%b rdata=%h exc=%0d rdy=%b), want 1 0000abcd 0 0", bad, a_out_valid, a_out_rdata, a_out_exc, a_in_ready);
        end
        vecs++;
        if (a_out_valid !== 1'b1 || a_out_rdata !== 32'h0000_ABCD) begin
            errs++;
            $display("FAIL resp_stall_end: valid=%b rdata=%h, want 1 0000abcd", a_out_valid, a_out_rdata);
        end
        drain32();
        vecs++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_bus_req !== 1'b0) begin
            errs++;
            $display("FAIL resp_stall_idle: valid=%b rdy=%b req=%b, want 0 1 0", a_out_valid, a_in_ready, a_bus_req);
        end
    endtask

    task automatic test_idle_ignore();
        a_bus_ack = 1'b1; a_bus_err = 1'b1; a_bus_rdata = 32'h7777_7777;
        repeat (2) @(negedge clk);
        a_bus_ack = 1'b0; a_bus_err = 1'b0;
        vecs++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_bus_req !== 1'b0) begin
            errs++;
            $display("FAIL idle_ignore: valid=%b rdy=%b req=%b, want 0 1 0", a_out_valid, a_in_ready, a_bus_req);
        end
        send32(4'h2, 32'h0000_0030, 32'h0);
        ack32(32'h0000_0007);
        vecs++;
        if (a_out_valid !== 1'b1 || a_out_exc !== 2'd0 || a_out_rdata !== 32'h7) begin
            errs++;
            $display("FAIL back_to_back: valid=%b exc=%0d rdata=%h, want 1 0 00000007", a_out_valid, a_out_exc, a_out_rdata);
        end
        drain32();
    endtask

    task automatic test_reset_mid_req();
        int bad;
        bad = 0;
        send32(4'h2, 32'h0000_0020, 32'h0);
        vecs++;
        if (a_bus_req !== 1'b1) begin
            errs++;
            $display("FAIL mid_req_pre: req=%b, want 1", a_bus_req);
        end
        #2 rst_n = 1'b0;
        #1;
        vecs++;
        if (a_bus_req !== 1'b0 || a_out_valid !== 1'b0) begin
            errs++;
            $display("FAIL mid_req_async: req=%b valid=%b, want 0 0", a_bus_req, a_out_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (a_out_valid !== 1'b0 || a_bus_req !== 1'b0 || a_in_ready !== 1'b1) bad++;
            a_bus_ack = (i == 0);
            @(negedge clk);
        end
        a_bus_ack = 1'b0;
        vecs++;
        if (bad != 0) begin
            errs++;
            $display("FAIL mid_req_after: %0d cycles with a response or request (valid=%b req=%b rdy=%b), want 0 0 1", bad, a_out_valid, a_bus_req, a_in_ready);
        end
    endtask

    task automatic test_wide64();
        send64(4'h1, 32'h0000_0006, 64'h0);
        vecs++;
        if (b_bus_req !== 1'b1 || b_bus_be !== 8'b1100_0000 || b_bus_addr !== 32'h0) begin
            errs++;
            $display("FAIL w64_lh_req: req=%b be=%b addr=%h, want 1 11000000 00000000", b_bus_req, b_bus_be, b_bus_addr);
        end
        ack64(64'h0000_0000_8001_0000);
        vecs++;
        if (b_out_valid !== 1'b1 || b_out_rdata !== 64'h0) begin
            errs++;
            $display("FAIL w64_lh_zero: valid=%b rdata=%h, want 1 0000000000000000", b_out_valid, b_out_rdata);
        end
        drain64();
        send64(4'h1, 32'h0000_0006, 64'h0);
        ack64(64'h8001_0000_0000_0000);
        vecs++;
        if (b_out_rdata !== 64'hFFFF_FFFF_FFFF_8001) begin
            errs++;
            $display("FAIL w64_lh_sign: rdata=%h, want ffffffffffff8001", b_out_rdata);
        end
        drain64();
        send64(4'h7, 32'h0000_0008, 64'h0);
        vecs++;
        if (b_bus_be !== 8'hFF || b_bus_addr !== 32'h8) begin
            errs++;
            $display("FAIL w64_ldu_req: be=%h addr=%h, want ff 00000008", b_bus_be, b_bus_addr);
        end
        ack64(64'h8000_0000_0000_0001);
        vecs++;
        if (b_out_rdata !== 64'h8000_0000_0000_0001 || b_out_exc !== 2'd0) begin
            errs++;
            $display("FAIL w64_ldu: rdata=%h exc=%0d, want 8000000000000001 0", b_out_rdata, b_out_exc);
        end
        drain64();
        send64(4'h6, 32'h0000_0004, 64'h0);
        ack64(64'h89AB_CDEF_0000_0000);
        vecs++;
        if (b_out_rdata !== 64'h0000_0000_89AB_CDEF) begin
            errs++;
            $display("FAIL w64_lwu: rdata=%h, want 0000000089abcdef", b_out_rdata);
        end
        drain64();
        send64(4'h2, 32'h0000_0004, 64'h0);
        ack64(64'h89AB_CDEF_0000_0000);
        vecs++;
        if (b_out_rdata !== 64'hFFFF_FFFF_89AB_CDEF) begin
            errs++;
            $display("FAIL w64_lw: rdata=%h, want ffffffff89abcdef", b_out_rdata);
        end
        drain64();
        send64(4'hA, 32'h0000_000C, 64'h0000_0000_1234_5678);
        vecs++;
        if (b_bus_we !== 1'b1 || b_bus_be !== 8'hF0 || b_bus_addr !== 32'h8 || b_bus_wdata !== 64'h1234_5678_0000_0000) begin
            errs++;
            $display("FAIL w64_sw_req: we=%b be=%h addr=%h wdata=%h, want 1 f0 00000008 1234567800000000", b_bus_we, b_bus_be, b_bus_addr, b_bus_wdata);
        end
        ack64(64'hFFFF_FFFF_FFFF_FFFF);
        drain64();
        send64(4'hB, 32'h0000_0004, 64'h0);
        vecs++;
        if (b_out_valid !== 1'b1 || b_out_exc !== 2'd2 || b_bus_req !== 1'b0) begin
            errs++;
            $display("FAIL w64_sd_misalign: valid=%b exc=%0d req=%b, want 1 2 0", b_out_valid, b_out_exc, b_bus_req);
        end
        drain64();
    endtask

    initial begin
        rst_n = 1'b0;
        a_in_valid = 1'b0; a_in_op = 4'h0; a_in_addr = 32'h0; a_in_wdata = 32'h0;
        a_bus_ack = 1'b0; a_bus_err = 1'b0; a_bus_rdata = 32'h0; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_op = 4'h0; b_in_addr = 32'h0; b_in_wdata = 64'h0;
        b_bus_ack = 1'b0; b_bus_err = 1'b0; b_bus_rdata = 64'h0; b_out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_load_byte();
        test_store();
        test_addr_exc();
        test_timeout();
        test_ack_err();
        test_resp_stall();
        test_idle_ignore();
        test_reset_mid_req();
        test_wide64();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
